// File: rtl/clk_div_ctrl_if.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl_if
// Purpose : groups the divisor request handshake and the divider control and
//           status outputs of clk_div_ctrl.
// Signals : req_valid  - divisor change request
//           req_div    - requested divisor
//           req_ready  - request accepted this cycle if req_valid
//           req_err    - one-cycle pulse, request rejected as out of range
//           div        - divisor to the clock divider
//           div_nrst   - active-low reset to the clock divider
//           locked     - divided clock stable at the current div
//           cfg_count  - accepted reconfiguration count
// Modports: master (requester side), slave (clk_div_ctrl side)
// -----------------------------------------------------------------------------
interface clk_div_ctrl_if;
    logic        req_valid;
    logic [31:0] req_div;
    logic        req_ready;
    logic        req_err;
    logic [31:0] div;
    logic        div_nrst;
    logic        locked;
    logic [15:0] cfg_count;

    modport master (
        output req_valid,
        output req_div,
        input  req_ready,
        input  req_err,
        input  div,
        input  div_nrst,
        input  locked,
        input  cfg_count
    );

    modport slave (
        input  req_valid,
        input  req_div,
        output req_ready,
        output req_err,
        output div,
        output div_nrst,
        output locked,
        output cfg_count
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
// Purpose : sequences divisor changes for an external clock divider. A new
//           divisor is applied while the divider is held in reset (HOLD), the
//           divider is released and allowed LOCK_PERIODS divided periods to
//           settle (WAIT), then the block reports lock and accepts new
//           requests (LOCKED).
// Ports   : clk  - reference clock, all state changes on its rising edge
//           rst  - synchronous active-high reset
//           bus  - clk_div_ctrl_if.slave (request handshake, div, div_nrst,
//                  locked, req_err, cfg_count)
// Config  : CLK_DIV_CTRL_STATUS_EN defined -> saturating count of accepted
//           reconfigurations on cfg_count; undefined -> cfg_count tied to 0.
// -----------------------------------------------------------------------------
module clk_div_ctrl #(
    parameter logic [31:0] DIV_DEFAULT  = 32'd1,
    parameter int unsigned HOLD_CYCLES  = 4,
    parameter int unsigned LOCK_PERIODS = 2
) (
    input logic           clk,
    input logic           rst,
    clk_div_ctrl_if.slave bus
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] WRAP_LAST = 8'(LOCK_PERIODS - 1);

    typedef enum logic [1:0] {
        StHold,
        StWait,
        StLocked
    } state_e;

    state_e      r_state;
    logic [7:0]  r_hold_cnt;
    logic [31:0] r_per_cnt;
    logic [7:0]  r_wrap_cnt;
    logic [31:0] r_div;
    logic        r_div_nrst;
    logic        r_locked;
    logic        r_req_ready;
    logic        r_req_err;

    state_e      w_state_nxt;
    logic [7:0]  w_hold_cnt_nxt;
    logic [31:0] w_per_cnt_nxt;
    logic [7:0]  w_wrap_cnt_nxt;
    logic [31:0] w_div_nxt;
    logic        w_req_err_nxt;
    logic        w_xfer;
    logic        w_req_bad;

    // r_req_ready is a register, so the handshake never loops back into ready.
    assign w_xfer    = bus.req_valid & r_req_ready;
    assign w_req_bad = (bus.req_div == 32'd0) || (bus.req_div == 32'hFFFF_FFFF);

    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        w_per_cnt_nxt  = r_per_cnt;
        w_wrap_cnt_nxt = r_wrap_cnt;
        w_div_nxt      = r_div;
        w_req_err_nxt  = 1'b0;

        unique case (r_state)
            StHold: begin
                if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nxt    = StWait;
                    w_hold_cnt_nxt = 8'd0;
                    w_per_cnt_nxt  = 32'd0;
                    w_wrap_cnt_nxt = 8'd0;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + 8'd1;
                end
            end
            StWait: begin
                // Period counter wraps every div cycles; the wrap counter
                // counts whole periods, giving LOCK_PERIODS*div cycles total.
                if (r_per_cnt == r_div - 32'd1) begin
                    w_per_cnt_nxt = 32'd0;
                    if (r_wrap_cnt == WRAP_LAST) begin
                        w_state_nxt    = StLocked;
                        w_wrap_cnt_nxt = 8'd0;
                    end else begin
                        w_wrap_cnt_nxt = r_wrap_cnt + 8'd1;
                    end
                end else begin
                    w_per_cnt_nxt = r_per_cnt + 32'd1;
                end
            end
            StLocked: begin
                if (w_xfer) begin
                    if (w_req_bad) begin
                        w_req_err_nxt = 1'b1;
                    end else if (bus.req_div != r_div) begin
                        // div only ever changes here, on entry to HOLD.
                        w_div_nxt      = bus.req_div;
                        w_state_nxt    = StHold;
                        w_hold_cnt_nxt = 8'd0;
                    end
                end
            end
            default: begin
                w_state_nxt    = StHold;
                w_hold_cnt_nxt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StHold;
            r_hold_cnt  <= 8'd0;
            r_per_cnt   <= 32'd0;
            r_wrap_cnt  <= 8'd0;
            r_div       <= DIV_DEFAULT;
            r_div_nrst  <= 1'b0;
            r_locked    <= 1'b0;
            r_req_ready <= 1'b0;
            r_req_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_per_cnt   <= w_per_cnt_nxt;
            r_wrap_cnt  <= w_wrap_cnt_nxt;
            r_div       <= w_div_nxt;
            // Outputs are registered copies decoded from the next state.
            r_div_nrst  <= (w_state_nxt != StHold);
            r_locked    <= (w_state_nxt == StLocked);
            r_req_ready <= (w_state_nxt == StLocked);
            r_req_err   <= w_req_err_nxt;
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.req_err   = r_req_err;
    assign bus.div       = r_div;
    assign bus.div_nrst  = r_div_nrst;
    assign bus.locked    = r_locked;

`ifdef CLK_DIV_CTRL_STATUS_EN
    logic [15:0] r_cfg_count;
    logic        w_reseq;

    assign w_reseq = (r_state == StLocked) & w_xfer & ~w_req_bad & (bus.req_div != r_div);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_count <= 16'd0;
        end else if (w_reseq && (r_cfg_count != 16'hFFFF)) begin
            r_cfg_count <= r_cfg_count + 16'd1;
        end
    end

    assign bus.cfg_count = r_cfg_count;
`else
    assign bus.cfg_count = 16'd0;
`endif

endmodule
